// File: rtl/f1_lights_seq.sv
// f1_lights_seq -- F1 start-light sequencer.
//
// When a rising edge is seen on trigger, the lamps light one at a time, one
// lamp per en tick, filling from bit 0. All lamps then stay lit for
// delay_in+1 en ticks. After that they all go dark and lights_out pulses
// for one cycle.
//
// Parameters:
//   WIDTH    number of lamps (>= 2)
//   DELAY_W  width of the hold-delay load value and counter
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   en         step tick; the FSM only advances when en=1
//   trigger    start request (rising-edge detected internally)
//   delay_in   hold length in extra ticks, captured on the FILL->HOLD edge
//   data_out   thermometer-coded lamp vector
//   cmd_seq    high while filling
//   cmd_delay  high while holding all lamps lit
//   lights_out one-cycle pulse on the extinguish edge
//   busy       high whenever not idle
//
// Optional feature (macro F1_AUTO_REARM_EN):
//   When this macro is defined and trigger is still high on the extinguish
//   edge, the FSM goes straight back to FILL instead of IDLE, so the
//   sequence keeps cycling while trigger is held.

module f1_lights_seq #(
  parameter int WIDTH   = 8,
  parameter int DELAY_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               trigger,
  input  logic [DELAY_W-1:0] delay_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               cmd_seq,
  output logic               cmd_delay,
  output logic               lights_out,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [DELAY_W-1:0] CNT_ONE = {{(DELAY_W-1){1'b0}}, 1'b1};

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   data_reg, data_next;
  logic [DELAY_W-1:0] cnt_reg, cnt_next;
  logic               trig_q_reg;
  logic               lights_out_reg, lights_out_next;
  logic               start;

  // trig_q follows trigger every cycle, whatever en is doing, so a start is
  // recognised even while en is low.
  assign start = trigger & ~trig_q_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      data_reg       <= '0;
      cnt_reg        <= '0;
      trig_q_reg     <= 1'b0;
      lights_out_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      data_reg       <= data_next;
      cnt_reg        <= cnt_next;
      trig_q_reg     <= trigger;
      lights_out_reg <= lights_out_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    data_next       = data_reg;
    cnt_next        = cnt_reg;
    lights_out_next = 1'b0;
    case (state_reg)
      IDLE: begin
        data_next = '0;
        if (start) begin
          state_next = FILL;
        end
      end
      FILL: begin
        if (en) begin
          data_next = {data_reg[WIDTH-2:0], 1'b1};
          // The shifted value is all ones exactly when the lower WIDTH-1
          // bits are already lit.
          if (&data_reg[WIDTH-2:0]) begin
            state_next = HOLD;
            cnt_next   = delay_in;
          end
        end
      end
      HOLD: begin
        if (en) begin
          if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CNT_ONE;
          end else begin
            data_next       = '0;
            lights_out_next = 1'b1;
            state_next      = IDLE;
`ifdef F1_AUTO_REARM_EN
            if (trigger) begin
              state_next = FILL;
            end
`endif
          end
        end
      end
      default: begin
        state_next = IDLE;
        data_next  = '0;
      end
    endcase
  end

  assign data_out   = data_reg;
  assign lights_out = lights_out_reg;
  assign cmd_seq    = (state_reg == FILL);
  assign cmd_delay  = (state_reg == HOLD);
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_f1_lights_seq.sv
// tb_f1_lights_seq -- scoreboard bench for f1_lights_seq (WIDTH=8, DELAY_W=7).
// The stimulus process pushes the hand-derived expected output set after each
// clock edge. A separate monitor pops each entry on the falling edge and
// compares it with the DUT outputs.

module tb_f1_lights_seq;

  localparam int WIDTH   = 8;
  localparam int DELAY_W = 7;
`ifdef F1_AUTO_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               trigger;
  logic [DELAY_W-1:0] delay_in;
  logic [WIDTH-1:0]   data_out;
  logic               cmd_seq;
  logic               cmd_delay;
  logic               lights_out;
  logic               busy;

  f1_lights_seq #(.WIDTH(WIDTH), .DELAY_W(DELAY_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .trigger   (trigger),
    .delay_in  (delay_in),
    .data_out  (data_out),
    .cmd_seq   (cmd_seq),
    .cmd_delay (cmd_delay),
    .lights_out(lights_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       seq;
    logic       dly;
    logic       lo;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  // Monitor: every cycle presents one output set. Compare it with the oldest
  // expected entry.
  always @(negedge clk) begin
    exp_t e;
    exp_t g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g.data = data_out;
      g.seq  = cmd_seq;
      g.dly  = cmd_delay;
      g.lo   = lights_out;
      g.busy = busy;
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL outputs cycle=%0d got data=%h seq=%b dly=%b lo=%b busy=%b exp data=%h seq=%b dly=%b lo=%b busy=%b",
                 cyc_n, g.data, g.seq, g.dly, g.lo, g.busy, e.data, e.seq, e.dly, e.lo, e.busy);
      end
      cyc_n++;
    end
  end

  // Drive the inputs for one edge and queue the outputs expected after that edge.
  task automatic cyc(input logic en_v, input logic trig_v, input logic [7:0] d,
                     input logic s, input logic dl, input logic lo, input logic b);
    exp_t e;
    en      = en_v;
    trigger = trig_v;
    @(posedge clk);
    #1;
    e.data = d;
    e.seq  = s;
    e.dly  = dl;
    e.lo   = lo;
    e.busy = b;
    exp_q.push_back(e);
  endtask

  // Trigger pattern used after the start edge:
  // 0 = low, 1 = held high, 2 = toggling (extra rising edges).
  function automatic logic tg(input int mode, input int c);
    if (mode == 1) return 1'b1;
    if (mode == 2) return (c % 2) == 1;
    return 1'b0;
  endfunction

  // One full sequence. en is high once every 'period' cycles.
  task automatic run_seq(input int delay, input int period, input int mode);
    logic [7:0] d;
    logic       t;
    logic       r;
    int         c;
    c = 0;
    t = 1'b0;
    r = 1'b0;
    $display("seq: delay=%0d period=%0d trig_mode=%0d", delay, period, mode);
    delay_in = delay[DELAY_W-1:0];
    // Start edge: FILL is entered but no lamp lights yet. When period>1,
    // en is low on this edge, which checks that the start ignores en.
    cyc((period == 1), 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    d = 8'h00;
    for (int k = 1; k <= WIDTH; k++) begin
      repeat (period - 1) begin
        c++;
        cyc(1'b0, tg(mode, c), d, 1'b1, 1'b0, 1'b0, 1'b1);
      end
      d = {d[6:0], 1'b1};
      c++;
      cyc(1'b1, tg(mode, c), d, (k < WIDTH), (k == WIDTH), 1'b0, 1'b1);
    end
    // This change falls after the load edge, so it must not alter the hold.
    delay_in = delay[DELAY_W-1:0] ^ 7'h55;
    for (int h = delay; h >= 0; h--) begin
      repeat (period - 1) begin
        c++;
        cyc(1'b0, tg(mode, c), 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
      end
      c++;
      if (h > 0) begin
        cyc(1'b1, tg(mode, c), 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
      end else begin
        t = (mode == 1);
        r = REARM && t;
        cyc(1'b1, t, 8'h00, r, 1'b0, 1'b1, r);
      end
    end
    // The pulse must be gone on the next cycle, even with en low.
    cyc(1'b0, t, 8'h00, r, 1'b0, 1'b0, r);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    trigger  = 1'b0;
    delay_in = '0;

    // Reset state, with trigger going high while reset is still asserted.
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Trigger held through reset starts on the first cycle after reset.
    run_seq(3, 1, 0);
    run_seq(3, 3, 0);
    run_seq(3, 1, 2);
    run_seq(0, 1, 0);
    run_seq(127, 1, 0);

    // Trigger held high for the whole sequence.
    run_seq(2, 1, 1);
    if (REARM) begin
      cyc(1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
    end else begin
      repeat (3) cyc(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      run_seq(1, 1, 0);
    end

    // Reset in the middle of FILL, when data_out is 0x1F.
    $display("seq: mid-fill reset");
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    delay_in = 7'd4;
    cyc(1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 8'h1F, 1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_seq(4, 1, 0);

    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d entries left in queue, exp 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
